// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: prediction modes, FSM states,
// and the saturating counter update used at resolve.
package bp_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_LOCAL   = 1;
    localparam int MODE_GSHARE  = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Increment or decrement ctr, clamped to [0, 2**width-1]; width must be 1..31.
    function automatic logic [31:0] sat_update(input logic [31:0] ctr,
                                               input logic        taken,
                                               input int          width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        if (taken) begin
            return (ctr >= max_val) ? max_val : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of saturating counters: asynchronous read, synchronous write,
// plus a dedicated init write port that takes priority during the clear sweep.
module sat_counter_table #(
    parameter int DEPTH_BITS = 8,
    parameter int WIDTH      = 2
) (
    input  logic                  clk_i,
    input  logic [DEPTH_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    input  logic                  wr_en,
    input  logic [DEPTH_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  init_en,
    input  logic [DEPTH_BITS-1:0] init_addr,
    input  logic [WIDTH-1:0]      init_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_BITS];

    always_ff @(posedge clk_i) begin
        if (init_en) begin
            mem[init_addr] <= init_data;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Predict must see the counter in the same cycle, so the read is not registered.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/branch_predictor_unit.sv
// Bimodal / local / gshare branch predictor with saturating counters,
// speculative history update at predict and repair on mispredict.
module branch_predictor_unit
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int HIST_BITS  = 8,
    parameter int CTR_BITS   = 2,
    parameter int MODE       = 1,
    parameter int PERF_BITS  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  ready_o,
    input  logic                  pred_valid_i,
    input  logic [INDEX_BITS-1:0] pred_pc_i,
    output logic                  pred_taken_o,
    output logic [CTR_BITS-1:0]   pred_ctr_o,
    output logic [HIST_BITS-1:0]  pred_hist_o,
    input  logic                  res_valid_i,
    input  logic [INDEX_BITS-1:0] res_pc_i,
    input  logic                  res_taken_i,
    input  logic [CTR_BITS-1:0]   res_ctr_i,
    input  logic [HIST_BITS-1:0]  res_hist_i,
    output logic                  mispredict_o,
    output logic [PERF_BITS-1:0]  branch_count_o,
    output logic [PERF_BITS-1:0]  mispredict_count_o
);

    localparam int IW = (INDEX_BITS > HIST_BITS) ? INDEX_BITS : HIST_BITS;
    localparam int CW = (MODE == MODE_LOCAL) ? HIST_BITS : INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(2 ** (CTR_BITS - 1));

    bp_state_e               state_reg;
    bp_state_e               state_next;
    logic [IW-1:0]           init_idx_reg;
    logic [HIST_BITS-1:0]    ghr_reg;
    logic [HIST_BITS-1:0]    hist_table [2**INDEX_BITS];
    logic [PERF_BITS-1:0]    branch_count_reg;
    logic [PERF_BITS-1:0]    mispredict_count_reg;
    logic                    run;
    logic [CW-1:0]           pred_idx;
    logic [CW-1:0]           res_idx;
    logic [CTR_BITS-1:0]     ctr_rd_data;
    logic [CTR_BITS-1:0]     ctr_wr_data;
    logic [HIST_BITS-1:0]    spec_hist;
    logic [HIST_BITS-1:0]    repair_hist;
    logic                    res_fire;
    logic                    repair_fire;

    // Counter index; the history term is the GHR at predict and the carried history at resolve.
    function automatic logic [CW-1:0] ctr_index(input logic [INDEX_BITS-1:0] pc,
                                                input logic [HIST_BITS-1:0]  hist);
        logic [IW-1:0] pc_ext;
        logic [IW-1:0] hist_ext;
        logic [IW-1:0] full;
        pc_ext   = IW'(pc);
        hist_ext = IW'(hist);
        if (MODE == MODE_LOCAL) begin
            full = hist_ext;
        end else if (MODE == MODE_GSHARE) begin
            full = pc_ext ^ hist_ext;
        end else begin
            full = pc_ext;
        end
        return full[CW-1:0];
    endfunction

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_INIT;
            init_idx_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_INIT) begin
                init_idx_reg <= init_idx_reg + 1'b1;
            end
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT: if (init_idx_reg == '1) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready_o = 1'b0;
        if (state_reg == ST_RUN) begin
            ready_o = 1'b1;
        end
    end

    assign run = ready_o;

    always_comb begin
        pred_hist_o = '0;
        if (MODE == MODE_LOCAL) begin
            pred_hist_o = hist_table[pred_pc_i];
        end else if (MODE == MODE_GSHARE) begin
            pred_hist_o = ghr_reg;
        end
    end

    assign pred_idx     = ctr_index(pred_pc_i, pred_hist_o);
    assign res_idx      = ctr_index(res_pc_i, res_hist_i);
    assign pred_ctr_o   = ctr_rd_data;
    assign pred_taken_o = run & ctr_rd_data[CTR_BITS-1];
    assign mispredict_o = res_valid_i & (res_taken_i != res_ctr_i[CTR_BITS-1]);
    assign ctr_wr_data  = CTR_BITS'(sat_update(32'(res_ctr_i), res_taken_i, CTR_BITS));
    assign res_fire     = run & res_valid_i;
    assign repair_fire  = res_fire & mispredict_o;
    assign spec_hist    = HIST_BITS'({pred_hist_o, pred_taken_o});
    assign repair_hist  = HIST_BITS'({res_hist_i, res_taken_i});

    sat_counter_table #(
        .DEPTH_BITS (CW),
        .WIDTH      (CTR_BITS)
    ) u_ctr_table (
        .clk_i     (clk_i),
        .rd_addr   (pred_idx),
        .rd_data   (ctr_rd_data),
        .wr_en     (res_fire),
        .wr_addr   (res_idx),
        .wr_data   (ctr_wr_data),
        .init_en   (!run),
        .init_addr (init_idx_reg[CW-1:0]),
        .init_data (CTR_INIT)
    );

    // Repair is written last so it overrides a speculative shift of the same entry.
    always_ff @(posedge clk_i) begin
        if (!run) begin
            hist_table[init_idx_reg[INDEX_BITS-1:0]] <= '0;
        end else if (!rst_i && MODE == MODE_LOCAL) begin
            if (pred_valid_i) begin
                hist_table[pred_pc_i] <= spec_hist;
            end
            if (repair_fire) begin
                hist_table[res_pc_i] <= repair_hist;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_reg <= '0;
        end else if (run && MODE == MODE_GSHARE) begin
            if (repair_fire) begin
                ghr_reg <= repair_hist;
            end else if (pred_valid_i) begin
                ghr_reg <= spec_hist;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else if (res_fire) begin
            if (branch_count_reg != '1) begin
                branch_count_reg <= branch_count_reg + 1'b1;
            end
            if (mispredict_o && mispredict_count_reg != '1) begin
                mispredict_count_reg <= mispredict_count_reg + 1'b1;
            end
        end
    end

    assign branch_count_o     = branch_count_reg;
    assign mispredict_count_o = mispredict_count_reg;

endmodule
